// File: rtl/onchip_memory_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// onchip_mem_pkg : shared types for the on-chip RAM port-2 arbiter
// Revision       : 1.0  initial release
// ============================================================================
package onchip_mem_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int RAM_WORDS   = 2048;

  typedef logic master_id_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/onchip_memory_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// onchip_memory_port_arbiter_if : single-beat Avalon-MM master bundle
// Revision                      : 1.0  initial release
// ============================================================================
interface onchip_memory_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface
`default_nettype wire

// File: rtl/onchip_memory_port_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// rr_arbiter2 : two-requester round-robin; last winner loses the next tie
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2
  import onchip_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       enable,
  output master_id_t grant,
  output logic       valid
);

  master_id_t last_grant_q;
  master_id_t last_grant_d;

  always_comb begin
    valid = |req;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = ~last_grant_q;
    endcase
    last_grant_d = (enable && valid) ? grant : last_grant_q;
  end

  // Reset to 1 so master 0 takes the first contested slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant_q <= 1'b1;
    else          last_grant_q <= last_grant_d;
  end

endmodule
`default_nettype wire

// File: rtl/onchip_memory_port_arbiter.sv
`default_nettype none
// ============================================================================
// onchip_memory_port_arbiter : shares RAM port 2 between two Avalon-MM masters
// Revision                   : 1.0  initial release
// ============================================================================
module onchip_memory_port_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int BE_W       = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  onchip_memory_port_arbiter_if.slave m0,
  onchip_memory_port_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [BE_W-1:0]             mem_byteenable,
  output logic                        mem_chipselect,
  output logic                        mem_write,
  output logic [DATA_W-1:0]           mem_writedata,
  output logic                        mem_clken,
  input  logic [DATA_W-1:0]           mem_readdata,
  output logic                        busy,
  output logic                        proto_err
);

  localparam logic [0:0] S_IDLE    = 1'(IDLE);
  localparam logic [0:0] S_RD_WAIT = 1'(RD_WAIT);

  logic [0:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  master_id_t        owner_q, owner_d;
  logic              ready_q;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              rdv0_q, rdv0_d, rdv1_q, rdv1_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   arb_enable;
  logic                   accept;
  master_id_t             grant;
  logic                   grant_valid;
  logic                   win_write;
  logic [ADDR_W-1:0]      win_addr;
  logic [BE_W-1:0]        win_be;
  logic [DATA_W-1:0]      win_data;

  assign req        = {m1.read | m1.write, m0.read | m0.write};
  // ready_q holds off grants (and chipselect) until the first edge after reset.
  assign arb_enable = ready_q && (state_q == S_IDLE);
  assign accept     = arb_enable && grant_valid;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .enable  (arb_enable),
    .grant   (grant),
    .valid   (grant_valid)
  );

  assign win_write = grant ? m1.write      : m0.write;
  assign win_addr  = grant ? m1.address    : m0.address;
  assign win_be    = grant ? m1.byteenable : m0.byteenable;
  assign win_data  = grant ? m1.writedata  : m0.writedata;

  assign mem_chipselect = accept;
  assign mem_write      = accept && win_write;
  assign mem_address    = win_addr;
  assign mem_byteenable = win_write ? win_be : {BE_W{1'b1}};
  assign mem_writedata  = win_data;
  assign mem_clken      = ready_q;
  assign busy           = (state_q == S_RD_WAIT);
  assign proto_err      = perr_q;

  assign m0.waitrequest   = ~(accept && (grant == 1'b0));
  assign m1.waitrequest   = ~(accept && (grant == 1'b1));
  assign m0.readdata      = rdata0_q;
  assign m1.readdata      = rdata1_q;
  assign m0.readdatavalid = rdv0_q;
  assign m1.readdatavalid = rdv1_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    rdv0_d   = 1'b0;
    rdv1_d   = 1'b0;
    perr_d   = perr_q | (m0.read & m0.write) | (m1.read & m1.write);
    case (state_q)
      S_IDLE: begin
        if (accept && !win_write) begin
          state_d = S_RD_WAIT;
          cnt_d   = 2'(RD_LATENCY);
          owner_d = grant;
        end
      end
      default: begin
        if (cnt_q == 2'd1) begin
          state_d = S_IDLE;
          if (owner_q) begin
            rdata1_d = mem_readdata;
            rdv1_d   = 1'b1;
          end else begin
            rdata0_d = mem_readdata;
            rdv0_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      owner_q  <= 1'b0;
      ready_q  <= 1'b0;
      perr_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      rdv0_q   <= 1'b0;
      rdv1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      ready_q  <= 1'b1;
      perr_q   <= perr_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      rdv0_q   <= rdv0_d;
      rdv1_q   <= rdv1_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_onchip_memory_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_onchip_memory_port_arbiter : directed + random bench with transaction model
// Revision                      : 1.0  initial release
// ============================================================================
module tb_onchip_memory_port_arbiter;
  import onchip_mem_pkg::*;

  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [31:0] mem_readdata;
  logic        busy;
  logic        proto_err;

  onchip_memory_port_arbiter_if #(.ADDR_W(11), .DATA_W(32), .BE_W(4)) m0_if ();
  onchip_memory_port_arbiter_if #(.ADDR_W(11), .DATA_W(32), .BE_W(4)) m1_if ();

  onchip_memory_port_arbiter #(
    .ADDR_W(11), .DATA_W(32), .BE_W(4), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .busy           (busy),
    .proto_err      (proto_err)
  );

  always #5 clk = ~clk;

  // RAM port 2 with registered address and unregistered q.
  logic [31:0] ram [0:RAM_WORDS-1];
  logic [10:0] ram_addr_q;
  assign mem_readdata = ram[ram_addr_q];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      ram_addr_q <= mem_address;
    end
  end

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc;
  bit          model_last;
  int          block_until;
  int          rdv_cycle [2];
  logic [31:0] rdv_data  [2];
  logic [31:0] last_rd   [2];
  bit          perr_m;
  logic [31:0] ref_mem [0:RAM_WORDS-1];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_m(input int m, input bit rd, input bit wr, input logic [10:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (m == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
      m0_if.byteenable = be; m0_if.writedata = d;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
      m1_if.byteenable = be; m1_if.writedata = d;
    end
  endtask

  task automatic idle_m(input int m);
    set_m(m, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
  endtask

  task automatic model_reset();
    cyc = 0; model_last = 1'b1; block_until = 0; perr_m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rdv_cycle[i] = -1; rdv_data[i] = '0; last_rd[i] = '0;
    end
  endtask

  // One bus cycle: compare DUT against the transaction model, then advance it.
  task automatic step(output bit a0, output bit a1);
    bit r0, r1, acc, win, ww, e0, e1, pe;
    logic [10:0] wa;
    logic [3:0]  wbe;
    logic [31:0] wd, tmp;
    @(negedge clk);
    r0  = m0_if.read | m0_if.write;
    r1  = m1_if.read | m1_if.write;
    pe  = (m0_if.read & m0_if.write) | (m1_if.read & m1_if.write);
    acc = (cyc >= block_until) && (r0 || r1);
    win = (r0 && r1) ? ~model_last : r1;
    ww  = win ? m1_if.write      : m0_if.write;
    wa  = win ? m1_if.address    : m0_if.address;
    wbe = win ? m1_if.byteenable : m0_if.byteenable;
    wd  = win ? m1_if.writedata  : m0_if.writedata;
    e0  = (rdv_cycle[0] == cyc);
    e1  = (rdv_cycle[1] == cyc);
    chk1("m0_waitrequest", m0_if.waitrequest, !(acc && !win));
    chk1("m1_waitrequest", m1_if.waitrequest, !(acc && win));
    chk1("m0_readdatavalid", m0_if.readdatavalid, e0);
    chk1("m1_readdatavalid", m1_if.readdatavalid, e1);
    chk32("m0_readdata", m0_if.readdata, e0 ? rdv_data[0] : last_rd[0]);
    chk32("m1_readdata", m1_if.readdata, e1 ? rdv_data[1] : last_rd[1]);
    chk1("busy", busy, cyc < block_until);
    chk1("mem_chipselect", mem_chipselect, acc);
    chk1("mem_clken", mem_clken, 1'b1);
    chk1("proto_err", proto_err, perr_m);
    if (acc) begin
      chk1("mem_write", mem_write, ww);
      chk32("mem_address", 32'(mem_address), 32'(wa));
      chk32("mem_byteenable", 32'(mem_byteenable), ww ? 32'(wbe) : 32'hF);
      if (ww) chk32("mem_writedata", mem_writedata, wd);
    end
    @(posedge clk);
    if (e0) last_rd[0] = rdv_data[0];
    if (e1) last_rd[1] = rdv_data[1];
    perr_m = perr_m | pe;
    if (acc) begin
      model_last = win;
      if (ww) begin
        tmp = ref_mem[wa];
        for (int b = 0; b < 4; b++) if (wbe[b]) tmp[8*b +: 8] = wd[8*b +: 8];
        ref_mem[wa] = tmp;
      end else begin
        rdv_cycle[win] = cyc + RD_LAT + 1;
        rdv_data[win]  = ref_mem[wa];
        block_until    = cyc + RD_LAT + 1;
      end
    end
    a0 = acc && !win;
    a1 = acc && win;
    cyc++;
    #1;
  endtask

  task automatic run_until_acc(input int m);
    bit a0, a1, got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      step(a0, a1);
      got = (m == 0) ? a0 : a1;
    end
    chk1("accept_timeout", got, 1'b1);
    idle_m(m);
  endtask

  task automatic reset_checks();
    chk1("rst_m0_waitrequest", m0_if.waitrequest, 1'b1);
    chk1("rst_m1_waitrequest", m1_if.waitrequest, 1'b1);
    chk1("rst_m0_readdatavalid", m0_if.readdatavalid, 1'b0);
    chk1("rst_m1_readdatavalid", m1_if.readdatavalid, 1'b0);
    chk32("rst_m0_readdata", m0_if.readdata, 32'h0);
    chk32("rst_m1_readdata", m1_if.readdata, 32'h0);
    chk1("rst_mem_chipselect", mem_chipselect, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_proto_err", proto_err, 1'b0);
    chk1("rst_mem_clken", mem_clken, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_m(0, 1'b1, 1'b0, 11'h005, 4'hF, 32'h0);
    set_m(1, 1'b0, 1'b1, 11'h006, 4'hF, 32'h1);
    @(negedge clk); reset_checks();
    @(negedge clk); reset_checks();
    idle_m(0); idle_m(1);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic read_word(input int m, input logic [10:0] a, input string tag,
                           input logic [31:0] exp);
    bit a0, a1;
    set_m(m, 1'b1, 1'b0, a, 4'hF, 32'h0);
    run_until_acc(m);
    step(a0, a1);
    step(a0, a1);
    chk32(tag, (m == 0) ? m0_if.readdata : m1_if.readdata, exp);
  endtask

  task automatic write_word(input int m, input logic [10:0] a, input logic [3:0] be,
                            input logic [31:0] d);
    set_m(m, 1'b0, 1'b1, a, be, d);
    run_until_acc(m);
  endtask

  task automatic launch(input int m);
    int  kind;
    bit  rd, wr;
    kind = int'($urandom_range(0, 19));
    rd   = (kind < 9) || (kind == 19);
    wr   = (kind >= 9);
    set_m(m, rd, wr, 11'(32'h20 + $urandom_range(0, 7)), 4'($urandom_range(1, 15)), $urandom);
  endtask

  initial begin
    bit a0, a1, p0, p1;
    int k0, k1;
    reset_n = 1'b0;
    idle_m(0); idle_m(1);
    model_reset();
    do_reset();

    // Both masters stream writes from reset: grants alternate, m0 first.
    k0 = 0; k1 = 0;
    set_m(0, 1'b0, 1'b1, 11'h020, 4'hF, 32'hA000_0000);
    set_m(1, 1'b0, 1'b1, 11'h021, 4'hF, 32'hB000_0000);
    for (int n = 0; n < 40 && (k0 < 4 || k1 < 4); n++) begin
      step(a0, a1);
      if (a0) begin
        k0++;
        if (k0 < 4) set_m(0, 1'b0, 1'b1, 11'(32'h20 + 2*k0), 4'hF, 32'hA000_0000 + 32'(k0));
        else idle_m(0);
      end
      if (a1) begin
        k1++;
        if (k1 < 4) set_m(1, 1'b0, 1'b1, 11'(32'h21 + 2*k1), 4'hF, 32'hB000_0000 + 32'(k1));
        else idle_m(1);
      end
    end
    chk1("alt_writes_done", (k0 == 4) && (k1 == 4), 1'b1);
    for (int k = 0; k < 8; k++)
      read_word(0, 11'(32'h20 + k), "alt_readback",
                ((k % 2) == 0 ? 32'hA000_0000 : 32'hB000_0000) + 32'(k / 2));

    write_word(0, 11'h005, 4'hF, 32'hDEAD_BEEF);
    read_word(0, 11'h005, "deadbeef_readback", 32'hDEAD_BEEF);

    // m1 read at the top address while m0 waits with a write.
    write_word(1, 11'h7FF, 4'hF, 32'h5A5A_0FF7);
    set_m(1, 1'b1, 1'b0, 11'h7FF, 4'hF, 32'h0);
    step(a0, a1);
    chk1("m1_read_accept", a1, 1'b1);
    idle_m(1);
    set_m(0, 1'b0, 1'b1, 11'h040, 4'hF, 32'h0404_0404);
    run_until_acc(0);
    chk32("m1_top_addr_data", m1_if.readdata, 32'h5A5A_0FF7);

    write_word(0, 11'h010, 4'hF, 32'h1122_3344);
    write_word(0, 11'h010, 4'h2, 32'h0000_AA00);
    read_word(0, 11'h010, "byte_merge", 32'h1122_AA44);

    // Read+write together behaves as a write and latches proto_err.
    set_m(0, 1'b1, 1'b1, 11'h030, 4'hF, 32'hC0FF_EE00);
    run_until_acc(0);
    step(a0, a1);
    step(a0, a1);
    chk1("proto_err_sticky", proto_err, 1'b1);
    read_word(0, 11'h030, "rw_as_write", 32'hC0FF_EE00);
    chk1("proto_err_held", proto_err, 1'b1);

    // Reset in the cycle after a read accept drops the read.
    set_m(0, 1'b1, 1'b0, 11'h005, 4'hF, 32'h0);
    run_until_acc(0);
    do_reset();
    read_word(0, 11'h010, "post_reset_read", 32'h1122_AA44);

    p0 = 1'b0; p1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin launch(0); p0 = 1'b1; end
      if (!p1 && $urandom_range(0, 3) != 0) begin launch(1); p1 = 1'b1; end
      step(a0, a1);
      if (a0) begin idle_m(0); p0 = 1'b0; end
      if (a1) begin idle_m(1); p1 = 1'b0; end
    end
    for (int i = 0; i < 20 && (p0 || p1); i++) begin
      step(a0, a1);
      if (a0) begin idle_m(0); p0 = 1'b0; end
      if (a1) begin idle_m(1); p1 = 1'b0; end
    end
    chk1("random_drain", p0 || p1, 1'b0);
    repeat (4) step(a0, a1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/onchip_memory_port_arbiter.md
Name: onchip_memory_port_arbiter

Overview:
Shares port 2 of the 2048x32 bidirectional dual-port on-chip RAM between two Avalon-MM masters, such as a DMA engine and a video or debug reader. Port 1 stays dedicated to the Nios II data master. The block applies round-robin arbitration, issues single-beat reads and writes to the RAM port, and returns read data with a readdatavalid pulse. It sits between the system interconnect and the RAM's s2 slave port.

Parameters:
ADDR_W, 11, word address width (2048 words)
DATA_W, 32, data width
BE_W, 4, byteenable width (DATA_W/8)
RD_LATENCY, 1, RAM cycles from address capture to valid q (unregistered output gives 1; legal range 1..3)

Ports:
clk  in  1  system clock, shared with RAM clk2
reset_n  in  1  asynchronous active-low reset
mX_address  in  ADDR_W  word address, one per master (m0_, m1_)
mX_byteenable  in  BE_W  write byte lanes, per master
mX_read  in  1  read request, held until accepted
mX_write  in  1  write request, held until accepted
mX_writedata  in  DATA_W  write data, per master
mX_waitrequest  out  1  high = request not accepted this cycle
mX_readdata  out  DATA_W  registered read data
mX_readdatavalid  out  1  one-cycle pulse, read data valid
mem_address  out  ADDR_W  to RAM address2
mem_byteenable  out  BE_W  to RAM byteenable2 (all ones on reads)
mem_chipselect  out  1  to RAM chipselect2
mem_write  out  1  to RAM write2
mem_writedata  out  DATA_W  to RAM writedata2
mem_clken  out  1  to RAM clken2, constant 1 after reset
mem_readdata  in  DATA_W  from RAM readdata2
busy  out  1  high while a read is outstanding
proto_err  out  1  sticky: a master asserted read and write together

Behaviour:
- Reset (async assert, sync deassert expected upstream) forces these values:
  - mX_waitrequest = 1, mX_readdatavalid = 0, mX_readdata = 0.
  - mem_chipselect = 0, mem_write = 0, busy = 0, proto_err = 0.
  - mem_clken = 0 during reset, 1 afterwards.
  - last_grant = 1, so m0 wins the first tie. FSM = IDLE. Latency counter = 0.
- FSM IDLE:
  - A request is (read | write) on a master. If one master requests, it wins. If both request, the master != last_grant wins.
  - In the same cycle, combinationally drive mem_* from the winner: mem_chipselect = 1, mem_write = winner write.
  - Deassert the winner's waitrequest. The loser keeps waitrequest = 1.
  - Update last_grant on the clock edge.
  - Write: accepted in one cycle; stay in IDLE. Back-to-back writes sustain 1 per cycle.
  - Read: latch grant id, set counter = RD_LATENCY, go to RD_WAIT.
- FSM RD_WAIT:
  - Both waitrequests = 1. mem_chipselect = 0. busy = 1. Counter decrements each cycle.
  - When counter reaches 1: register mem_readdata into the owner's mX_readdata, then go to IDLE.
  - The owner's mX_readdatavalid pulses the following cycle.
  - Read latency from the accept cycle N (RD_LATENCY = 1): data captured at the end of N+1, readdatavalid high in N+2.
  - A new grant may occur in N+2, concurrently with the readdatavalid pulse.
- Non-owner readdata holds its last value. readdatavalid is never high for both masters.
- Read and write asserted together by one master: treat as a write (read ignored) and set proto_err; it stays set until reset.
- Requests must be held stable while waitrequest = 1. Address changes during the wait are not tracked; the value in the accept cycle is used.
- Reset mid-read: the transaction is dropped, with no readdatavalid pulse. A RAM write in the reset cycle is suppressed because mem_chipselect is forced to 0.
- Address wrap: none; the full ADDR_W range maps 1:1 to RAM words.

Decomposition:
- Shared package onchip_mem_pkg holds:
  - typedef arb_state_t {IDLE, RD_WAIT}
  - localparams NUM_MASTERS = 2, RAM_WORDS = 2048
  - typedef master_id_t (1 bit)
- One natural sub-module: rr_arbiter2, a 2-input round-robin with last_grant register and grant/valid outputs. It is reused by other shared-port blocks.

Test Plan:
- m0 writes 0xDEADBEEF to addr 0x005, byteenable 0xF, then reads addr 0x005 → waitrequest low in the accept cycle; m0_readdatavalid exactly 2 cycles after the read accept, with m0_readdata = 0xDEADBEEF.
- m0 and m1 both write continuously from reset → grants alternate m0, m1, m0, ...; each master is accepted every other cycle, and no write is lost (read back 8 words).
- m1 reads 0x7FF while m0 requests a write → m0 waitrequest stays high through RD_WAIT; m0 is accepted in the readdatavalid cycle; m1 gets the correct data.
- Byte write: 0x11223344 to addr 0x010, then byteenable 0x2 with data 0x0000AA00 → readback = 0x1122AA44.
- m0 asserts read and write together → treated as a write; proto_err goes high and remains high until reset_n pulses low.
- reset_n asserted in the cycle after a read accept → no readdatavalid; all outputs at reset values; a fresh read after release returns correct data.
